// File: rtl/e2prom_rw_test.sv
// ---------------------------------------------------------------------------
// e2prom_rw_test
//
// Self-test sequencer for the E2PROM. It drives the I2C byte driver so that
// BYTE_NUM consecutive addresses are written with a known pattern
// (data = low byte of the address). Each address is then read back and
// compared. The outcome goes to the LED status block as a one-cycle
// completion pulse plus a pass/fail flag that is held afterwards.
//
// Parameters:
//   BYTE_NUM   number of bytes tested, addresses 0..BYTE_NUM-1 (1..65535)
//   START_DLY  idle cycles after reset release before the first transaction
//   WR_WAIT    cycles waited after each completed write (E2PROM tWR)
//   TIMEOUT    cycles allowed for i2c_done, counted from the i2c_exec cycle
//
// Ports:
//   clk         clock shared with the I2C driver
//   rst_n       asynchronous active-low reset
//   i2c_exec    one-cycle transaction start pulse to the I2C driver
//   i2c_rh_wl   transaction type, 1 = read, 0 = write
//   i2c_addr    E2PROM byte address
//   i2c_data_w  write data
//   i2c_data_r  read data, valid while i2c_done = 1
//   i2c_done    one-cycle pulse, transaction finished
//   i2c_ack     1 = slave NACK/error, valid while i2c_done = 1
//   rw_done     one-cycle pulse, test finished
//   rw_result   1 = pass, 0 = fail; valid from rw_done onward, then held
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module e2prom_rw_test #(
    parameter logic [15:0] BYTE_NUM  = 16'd256,
    parameter logic [15:0] START_DLY = 16'd1000,
    parameter logic [15:0] WR_WAIT   = 16'd5000,
    parameter logic [19:0] TIMEOUT   = 20'd100_000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        i2c_exec,
    output logic        i2c_rh_wl,
    output logic [15:0] i2c_addr,
    output logic [7:0]  i2c_data_w,
    input  logic [7:0]  i2c_data_r,
    input  logic        i2c_done,
    input  logic        i2c_ack,
    output logic        rw_done,
    output logic        rw_result
);

    typedef enum logic [2:0] {
        S_INIT,
        S_WR_ISSUE,
        S_WR_BUSY,
        S_WR_WAIT,
        S_RD_ISSUE,
        S_RD_BUSY,
        S_DONE
    } state_t;

    state_t      state;
    logic [15:0] idx;
    logic [15:0] dly_cnt;
    logic [19:0] tmo_cnt;

    logic        last_idx;
    logic [15:0] idx_next;
    logic        init_expired;
    logic        wait_expired;
    logic        tmo_expired;
    logic        rd_match;

    // The delay and timeout compares are done one bit wider with "+1" so
    // that a parameter value of 0 behaves like 1 instead of wrapping around.
    assign last_idx     = (idx == (BYTE_NUM - 16'd1));
    assign idx_next     = idx + 16'd1;
    assign init_expired = (({1'b0, dly_cnt} + 17'd1) >= {1'b0, START_DLY});
    assign wait_expired = (({1'b0, dly_cnt} + 17'd1) >= {1'b0, WR_WAIT});
    assign tmo_expired  = (({1'b0, tmo_cnt} + 21'd1) >= {1'b0, TIMEOUT});
    assign rd_match     = (i2c_data_r == idx[7:0]);

    // Sequencer. Every output is a register: the transaction fields are
    // loaded on the transition into an ISSUE state so that i2c_exec is high
    // for exactly the ISSUE cycle, and the fields then stay untouched through
    // the following BUSY state. The timeout counter is loaded with 1 when
    // leaving ISSUE, so the exec cycle itself counts towards TIMEOUT.
    // i2c_done is only looked at in the BUSY states and is ignored elsewhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_INIT;
            idx        <= 16'd0;
            dly_cnt    <= 16'd0;
            tmo_cnt    <= 20'd0;
            i2c_exec   <= 1'b0;
            i2c_rh_wl  <= 1'b0;
            i2c_addr   <= 16'd0;
            i2c_data_w <= 8'd0;
            rw_done    <= 1'b0;
            rw_result  <= 1'b0;
        end else begin
            i2c_exec <= 1'b0;
            rw_done  <= 1'b0;

            case (state)
                S_INIT: begin
                    if (init_expired) begin
                        dly_cnt    <= 16'd0;
                        state      <= S_WR_ISSUE;
                        i2c_exec   <= 1'b1;
                        i2c_rh_wl  <= 1'b0;
                        i2c_addr   <= idx;
                        i2c_data_w <= idx[7:0];
                    end else begin
                        dly_cnt <= dly_cnt + 16'd1;
                    end
                end

                S_WR_ISSUE: begin
                    tmo_cnt <= 20'd1;
                    state   <= S_WR_BUSY;
                end

                S_WR_BUSY: begin
                    if (i2c_done) begin
                        if (i2c_ack) begin
                            state     <= S_DONE;
                            rw_done   <= 1'b1;
                            rw_result <= 1'b0;
                        end else begin
                            dly_cnt <= 16'd0;
                            state   <= S_WR_WAIT;
                        end
                    end else if (tmo_expired) begin
                        state     <= S_DONE;
                        rw_done   <= 1'b1;
                        rw_result <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 20'd1;
                    end
                end

                // After the last write the index wraps to 0 and the read
                // phase starts directly, reusing the same write-cycle wait.
                S_WR_WAIT: begin
                    if (wait_expired) begin
                        dly_cnt  <= 16'd0;
                        i2c_exec <= 1'b1;
                        if (last_idx) begin
                            idx       <= 16'd0;
                            state     <= S_RD_ISSUE;
                            i2c_rh_wl <= 1'b1;
                            i2c_addr  <= 16'd0;
                        end else begin
                            idx        <= idx_next;
                            state      <= S_WR_ISSUE;
                            i2c_rh_wl  <= 1'b0;
                            i2c_addr   <= idx_next;
                            i2c_data_w <= idx_next[7:0];
                        end
                    end else begin
                        dly_cnt <= dly_cnt + 16'd1;
                    end
                end

                S_RD_ISSUE: begin
                    tmo_cnt <= 20'd1;
                    state   <= S_RD_BUSY;
                end

                S_RD_BUSY: begin
                    if (i2c_done) begin
                        if (i2c_ack || !rd_match) begin
                            state     <= S_DONE;
                            rw_done   <= 1'b1;
                            rw_result <= 1'b0;
                        end else if (last_idx) begin
                            state     <= S_DONE;
                            rw_done   <= 1'b1;
                            rw_result <= 1'b1;
                        end else begin
                            idx       <= idx_next;
                            state     <= S_RD_ISSUE;
                            i2c_exec  <= 1'b1;
                            i2c_rh_wl <= 1'b1;
                            i2c_addr  <= idx_next;
                        end
                    end else if (tmo_expired) begin
                        state     <= S_DONE;
                        rw_done   <= 1'b1;
                        rw_result <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 20'd1;
                    end
                end

                // Terminal: only reset leaves, rw_result keeps its value.
                S_DONE: begin
                    state <= S_DONE;
                end

                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_e2prom_rw_test.sv
// ---------------------------------------------------------------------------
// tb_e2prom_rw_test
//
// Bench for e2prom_rw_test. Two instances are built, one with BYTE_NUM=4 and
// one with BYTE_NUM=1. Both use START_DLY=5, WR_WAIT=10 and TIMEOUT=200.
// Only the selected instance is out of reset. A behavioural I2C/E2PROM
// responder answers each i2c_exec 20 cycles later from a small memory model.
// A scoreboard queue holds the expected transaction sequence and is consumed
// as the DUT issues transactions.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_e2prom_rw_test;

    localparam int RESP_LAT  = 20;
    localparam int START_DLY = 5;
    localparam int WR_WAIT   = 10;
    localparam int TIMEOUT   = 200;
    localparam int BUDGET    = 5000;

    localparam int M_CLEAN = 0;
    localparam int M_RDATA = 1;
    localparam int M_WACK  = 2;
    localparam int M_HOLD  = 3;
    localparam int M_SPUR  = 4;
    localparam int M_RST   = 5;

    localparam int LAT_DONE = 0;
    localparam int LAT_TMO  = 1;

    typedef struct packed {
        logic        rh;
        logic [15:0] addr;
        logic [7:0]  data;
    } txn_t;

    typedef struct {
        int sel;
        int mode;
        int fault;
        int exp_res;
        int exp_wr;
        int exp_rd;
        int lat_kind;
        int tail;
    } scn_t;

    logic clk;
    logic rst4_n;
    logic rst1_n;
    logic sel;
    logic cur_rst;

    logic       i2c_done;
    logic       i2c_ack;
    logic [7:0] i2c_data_r;

    logic        exec4, rh4, done4, res4;
    logic [15:0] addr4;
    logic [7:0]  dw4;
    logic        exec1, rh1, done1, res1;
    logic [15:0] addr1;
    logic [7:0]  dw1;

    logic        exec, rh, rw_done, rw_result;
    logic [15:0] addr;
    logic [7:0]  dw;

    e2prom_rw_test #(
        .BYTE_NUM (16'd4),
        .START_DLY(16'd5),
        .WR_WAIT  (16'd10),
        .TIMEOUT  (20'd200)
    ) dut4 (
        .clk       (clk),
        .rst_n     (rst4_n),
        .i2c_exec  (exec4),
        .i2c_rh_wl (rh4),
        .i2c_addr  (addr4),
        .i2c_data_w(dw4),
        .i2c_data_r(i2c_data_r),
        .i2c_done  (i2c_done),
        .i2c_ack   (i2c_ack),
        .rw_done   (done4),
        .rw_result (res4)
    );

    e2prom_rw_test #(
        .BYTE_NUM (16'd1),
        .START_DLY(16'd5),
        .WR_WAIT  (16'd10),
        .TIMEOUT  (20'd200)
    ) dut1 (
        .clk       (clk),
        .rst_n     (rst1_n),
        .i2c_exec  (exec1),
        .i2c_rh_wl (rh1),
        .i2c_addr  (addr1),
        .i2c_data_w(dw1),
        .i2c_data_r(i2c_data_r),
        .i2c_done  (i2c_done),
        .i2c_ack   (i2c_ack),
        .rw_done   (done1),
        .rw_result (res1)
    );

    // The responder and checks always look at whichever instance is selected.
    assign cur_rst   = sel ? rst1_n : rst4_n;
    assign exec      = sel ? exec1  : exec4;
    assign rh        = sel ? rh1    : rh4;
    assign addr      = sel ? addr1  : addr4;
    assign dw        = sel ? dw1    : dw4;
    assign rw_done   = sel ? done1  : done4;
    assign rw_result = sel ? res1   : res4;

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_compared;
    int n_mismatched;
    int cur_scn;

    int cfg_mode;
    int cfg_fault;
    int cfg_bytes;

    txn_t       exp_q[$];
    logic [7:0] mem [256];

    int   cyc;
    logic in_reset;
    int   rel_cyc;
    logic pending;
    logic withheld;
    int   lat_cnt;
    txn_t cur;
    int   exec_cnt, wr_cnt, rd_cnt, done_pulses;
    int   done_cyc, last_exec_cyc, last_done_drive, last_wr_done_edge, spur_at;
    logic has_prev, prev_rh;
    logic got_result;

    scn_t tbl [7];

    // One comparison: counts it, and reports it when the values differ.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, required %0d (scenario %0d, cycle %0d)",
                     name, actual, expected, cur_scn, cyc);
        end
    endtask

    // Reference model of the transaction sequence for the current scenario:
    // writes 0..N-1 then reads 0..N-1, cut short right after the faulted one.
    function automatic void buildExpected();
        logic aborted;
        txn_t t;
        exp_q.delete();
        aborted = 1'b0;
        for (int a = 0; a < cfg_bytes; a++) begin
            t.rh   = 1'b0;
            t.addr = 16'(a);
            t.data = 8'(a);
            exp_q.push_back(t);
            if (cfg_mode == M_WACK && a == cfg_fault) begin
                aborted = 1'b1;
                break;
            end
        end
        if (!aborted) begin
            for (int a = 0; a < cfg_bytes; a++) begin
                t.rh   = 1'b1;
                t.addr = 16'(a);
                t.data = 8'h00;
                exp_q.push_back(t);
                if ((cfg_mode == M_RDATA || cfg_mode == M_HOLD) && a == cfg_fault)
                    break;
            end
        end
    endfunction

    // Per-run trackers go back to their idle values whenever reset is seen.
    function automatic void clearTrackers();
        pending           = 1'b0;
        withheld          = 1'b0;
        lat_cnt           = 0;
        exec_cnt          = 0;
        wr_cnt            = 0;
        rd_cnt            = 0;
        done_pulses       = 0;
        done_cyc          = -1;
        last_exec_cyc     = -1;
        last_done_drive   = -1;
        last_wr_done_edge = -1;
        spur_at           = -1;
        has_prev          = 1'b0;
        prev_rh           = 1'b0;
        got_result        = 1'b0;
    endfunction

    // One clock of the bench: sample the DUT 1 ns after the rising edge,
    // check it against the scoreboard, then drive the responder inputs for
    // the next edge. i2c_done is a single-cycle pulse by construction.
    task automatic tick();
        logic new_exec;
        @(posedge clk);
        #1;
        cyc++;
        i2c_done = 1'b0;
        i2c_ack  = 1'b0;
        new_exec = 1'b0;

        if (!cur_rst) begin
            checkOutput("rst_exec",      32'(exec),      0);
            checkOutput("rst_rh_wl",     32'(rh),        0);
            checkOutput("rst_addr",      32'(addr),      0);
            checkOutput("rst_data_w",    32'(dw),        0);
            checkOutput("rst_rw_done",   32'(rw_done),   0);
            checkOutput("rst_rw_result", 32'(rw_result), 0);
            in_reset = 1'b1;
            clearTrackers();
            buildExpected();
            return;
        end

        if (in_reset) begin
            in_reset = 1'b0;
            rel_cyc  = cyc - 1;
        end

        if (rw_done) begin
            done_pulses++;
            done_cyc   = cyc;
            got_result = rw_result;
        end

        if (exec) begin
            txn_t e;
            new_exec = 1'b1;
            exec_cnt++;
            checkOutput("one_outstanding", 32'(pending), 0);
            checkOutput("no_exec_after_done", 32'(done_pulses), 0);
            checkOutput("sb_has_entry", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("txn_rh_wl", 32'(rh),   32'(e.rh));
                checkOutput("txn_addr",  32'(addr), 32'(e.addr));
                if (!e.rh)
                    checkOutput("txn_data_w", 32'(dw), 32'(e.data));
            end
            if (exec_cnt == 1)
                checkOutput("start_delay", 32'(cyc - rel_cyc), START_DLY);
            if (has_prev && !prev_rh)
                checkOutput("write_wait_ok", 32'((cyc - last_wr_done_edge) >= WR_WAIT), 1);
            if (rh) rd_cnt++;
            else    wr_cnt++;
            has_prev      = 1'b1;
            prev_rh       = rh;
            last_exec_cyc = cyc;
            pending       = 1'b1;
            withheld      = 1'b0;
            lat_cnt       = RESP_LAT;
            cur.rh        = rh;
            cur.addr      = addr;
            cur.data      = dw;
        end else if (pending) begin
            checkOutput("hold_rh_wl", 32'(rh),   32'(cur.rh));
            checkOutput("hold_addr",  32'(addr), 32'(cur.addr));
            if (!cur.rh)
                checkOutput("hold_data_w", 32'(dw), 32'(cur.data));
        end

        if (pending && !withheld && !new_exec) begin
            lat_cnt--;
            if (lat_cnt == 0) begin
                if (cfg_mode == M_HOLD && cur.rh && int'(cur.addr) == cfg_fault) begin
                    withheld = 1'b1;
                end else begin
                    pending         = 1'b0;
                    i2c_done        = 1'b1;
                    last_done_drive = cyc;
                    if (cur.rh) begin
                        i2c_data_r = mem[cur.addr[7:0]];
                        if (cfg_mode == M_RDATA && int'(cur.addr) == cfg_fault)
                            i2c_data_r = 8'h07;
                    end else begin
                        mem[cur.addr[7:0]] = cur.data;
                        i2c_data_r         = 8'h00;
                        last_wr_done_edge  = cyc + 1;
                        spur_at            = cyc + 5;
                        if (cfg_mode == M_WACK && int'(cur.addr) == cfg_fault)
                            i2c_ack = 1'b1;
                    end
                end
            end
        end else if (cfg_mode == M_SPUR && !pending &&
                     (cyc == rel_cyc + 2 || cyc == spur_at)) begin
            // Deliberately hostile stray completion: NACK plus wrong data.
            i2c_done   = 1'b1;
            i2c_ack    = 1'b1;
            i2c_data_r = 8'hA5;
        end
    endtask

    // Runs one table row: reset, release, wait (bounded) for rw_done,
    // optionally pulse reset mid-read, idle for the tail, then compare the
    // outcome counters and completion timing against the row.
    task automatic applyStimulus(input int s);
        scn_t r;
        logic rst_fired;
        r         = tbl[s];
        cur_scn   = s + 1;
        sel       = r.sel[0];
        cfg_mode  = r.mode;
        cfg_fault = r.fault;
        cfg_bytes = r.sel != 0 ? 1 : 4;
        rst_fired = 1'b0;
        for (int a = 0; a < 256; a++) mem[a] = 8'hFF;
        rst4_n = 1'b0;
        rst1_n = 1'b0;
        repeat (3) tick();
        if (r.sel != 0) rst1_n = 1'b1;
        else            rst4_n = 1'b1;

        for (int n = 0; n < BUDGET && done_pulses == 0; n++) begin
            tick();
            if (cfg_mode == M_RST && !rst_fired && rd_cnt == cfg_fault + 1 &&
                cyc - last_exec_cyc == 5) begin
                rst_fired = 1'b1;
                rst4_n    = 1'b0;
                #1;
                checkOutput("async_rst_addr",  32'(addr), 0);
                checkOutput("async_rst_rh_wl", 32'(rh),   0);
                repeat (3) tick();
                rst4_n = 1'b1;
            end
        end
        checkOutput("rw_done_within_budget", 32'(done_pulses), 1);

        repeat (r.tail) tick();

        checkOutput("rw_done_pulses",  32'(done_pulses), 1);
        checkOutput("rw_result",       32'(got_result),  32'(r.exp_res));
        checkOutput("rw_result_held",  32'(rw_result),   32'(r.exp_res));
        checkOutput("write_count",     32'(wr_cnt),      32'(r.exp_wr));
        checkOutput("read_count",      32'(rd_cnt),      32'(r.exp_rd));
        checkOutput("exec_count",      32'(exec_cnt),    32'(r.exp_wr + r.exp_rd));
        checkOutput("sb_drained",      32'(exp_q.size()), 0);
        if (r.lat_kind == LAT_TMO)
            checkOutput("timeout_latency", 32'(done_cyc - last_exec_cyc), TIMEOUT);
        else
            checkOutput("done_latency", 32'(done_cyc - last_done_drive), 1);
    endtask

    // Scenario table, then sequential execution and the summary line.
    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        cyc          = 0;
        cur_scn      = 0;
        in_reset     = 1'b1;
        rel_cyc      = 0;
        sel          = 1'b0;
        rst4_n       = 1'b0;
        rst1_n       = 1'b0;
        i2c_done     = 1'b0;
        i2c_ack      = 1'b0;
        i2c_data_r   = 8'h00;
        cfg_mode     = M_CLEAN;
        cfg_fault    = 0;
        cfg_bytes    = 4;
        cur          = '0;
        clearTrackers();

        //         sel mode     fault res wr rd lat       tail
        tbl[0] = '{0, M_CLEAN, 0,    1,  4, 4, LAT_DONE, 1000};
        tbl[1] = '{0, M_RDATA, 2,    0,  4, 3, LAT_DONE, 50};
        tbl[2] = '{0, M_WACK,  1,    0,  2, 0, LAT_DONE, 50};
        tbl[3] = '{0, M_HOLD,  0,    0,  4, 1, LAT_TMO,  50};
        tbl[4] = '{0, M_RST,   1,    1,  4, 4, LAT_DONE, 50};
        tbl[5] = '{0, M_SPUR,  0,    1,  4, 4, LAT_DONE, 50};
        tbl[6] = '{1, M_SPUR,  0,    1,  1, 1, LAT_DONE, 50};

        for (int s = 0; s < 7; s++) begin
            $display("[TB] scenario %0d start", s + 1);
            applyStimulus(s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
